// File: rtl/vis_pkg.sv
// -----------------------------------------------------------------------------
// vis_pkg
// Shared definitions for the visibility frame controller.
//   state_e       controller state (IDLE, ARM, RUN)
//   VIS_*         default loop lengths, frame length and bank count
//   cnt_w()       counter/index width helper (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package vis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int VIS_LOOP0  = 3;
  localparam int VIS_LOOP1  = 5;
  localparam int VIS_COUNT  = VIS_LOOP0 * VIS_LOOP1;
  localparam int VIS_BLOCKS = 1024;
  localparam int VIS_BANKS  = 2;
  localparam int VIS_BSB    = $clog2(VIS_BANKS) - 1;

  // Width of a counter that runs 0..n-1; a 1-deep counter still gets 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vis_bank_alloc.sv
// -----------------------------------------------------------------------------
// vis_bank_alloc
// Output-bank bookkeeping: per-bank full flags, reader release and the
// lowest-index free-bank priority encoder.
//   clock, reset_n      clock, synchronous active-low reset
//   set_i, set_bank_i   mark a bank full (frame completed into it)
//   rel_i, rel_bank_i   reader releases a bank (ignored if not full/out of range)
//   excl_en_i/_bank_i   hide the bank currently being written from the search
//   full_o              registered full flags
//   free_any_o          at least one eligible bank is free
//   free_idx_o          lowest-index eligible free bank
// The search uses the registered flags only, so a release becomes visible to
// allocation one cycle after it is applied.
// -----------------------------------------------------------------------------
module vis_bank_alloc
  import vis_pkg::*;
#(
  parameter int BANKS = VIS_BANKS,
  parameter int BW    = cnt_w(BANKS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             set_i,
  input  logic [BW-1:0]    set_bank_i,
  input  logic             rel_i,
  input  logic [BW-1:0]    rel_bank_i,
  input  logic             excl_en_i,
  input  logic [BW-1:0]    excl_bank_i,
  output logic [BANKS-1:0] full_o,
  output logic             free_any_o,
  output logic [BW-1:0]    free_idx_o
);

  logic [BANKS-1:0] full_q, full_d;
  logic [BANKS-1:0] avail;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    full_d = full_q;
    if (rel_i && (int'(rel_bank_i) < BANKS)) full_d[rel_bank_i] = 1'b0;
    // A set and a release on different banks both land; on the same bank the
    // bank is still being written (not full), so the set wins.
    if (set_i) full_d[set_bank_i] = 1'b1;
  end

  always_comb begin
    avail = ~full_q;
    if (excl_en_i) avail[excl_bank_i] = 1'b0;
    free_any_o = |avail;
    free_idx_o = '0;
    // Walk downward so the lowest free index is the last one written.
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (avail[i]) free_idx_o = BW'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) full_q <= '0;
    else          full_q <= full_d;
  end

  assign full_o = full_q;

endmodule

// File: rtl/vis_frame_ctrl.sv
// -----------------------------------------------------------------------------
// vis_frame_ctrl
// Sequencing controller for the correlator array and its banked visibility
// SRAM. Counts accepted samples into inner/outer loops, partial-sum blocks and
// integration frames, and allocates/fills output banks.
//   clock, reset_n          clock, synchronous active-low reset
//   enable_i                run request
//   valid_i                 sample valid (one sample per cycle)
//   rel_i, rel_bank_i       reader releases a bank
//   valid_o/first_o/next_o/last_o, cntlo_o/cnthi_o
//                           per-sample strobes and counters, 1 cycle after accept
//   wbank_o                 bank currently being written
//   vis_start_o             first sample of a frame
//   vis_frame_o             frame completed (cycle after last_o)
//   bank_full_o             per-bank data-awaiting-readout flags
//   overflow_o              sticky: samples dropped for lack of a free bank
// Optional macro FRAME_SEQ_EN adds frame_seq_o (completed-frame counter) and
// bank_seq_o (frame number last written into each bank).
// -----------------------------------------------------------------------------
module vis_frame_ctrl
  import vis_pkg::*;
#(
  parameter int LOOP0  = VIS_LOOP0,
  parameter int LOOP1  = VIS_LOOP1,
  parameter int BLOCKS = VIS_BLOCKS,
  parameter int BANKS  = VIS_BANKS
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic                      valid_i,
  input  logic                      rel_i,
  input  logic [cnt_w(BANKS)-1:0]   rel_bank_i,
  output logic                      valid_o,
  output logic                      first_o,
  output logic                      next_o,
  output logic                      last_o,
  output logic [cnt_w(LOOP0)-1:0]   cntlo_o,
  output logic [cnt_w(LOOP1)-1:0]   cnthi_o,
  output logic [cnt_w(BANKS)-1:0]   wbank_o,
  output logic                      vis_start_o,
  output logic                      vis_frame_o,
  output logic [BANKS-1:0]          bank_full_o,
  output logic                      overflow_o
`ifdef FRAME_SEQ_EN
  ,
  output logic [15:0]               frame_seq_o,
  output logic [BANKS*16-1:0]       bank_seq_o
`endif
);

  localparam int LW  = cnt_w(LOOP0);
  localparam int HW  = cnt_w(LOOP1);
  localparam int KW  = cnt_w(BLOCKS);
  localparam int BW  = cnt_w(BANKS);
  localparam logic [LW-1:0] LO_MAX  = LW'(LOOP0 - 1);
  localparam logic [HW-1:0] HI_MAX  = HW'(LOOP1 - 1);
  localparam logic [KW-1:0] BLK_MAX = KW'(BLOCKS - 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   lo_q, lo_d;          // index of the next sample to accept
  logic [HW-1:0]   hi_q, hi_d;
  logic [KW-1:0]   blk_q, blk_d;
  logic [BW-1:0]   wbank_q, wbank_d;
  logic [LW-1:0]   cntlo_q, cntlo_d;    // index of the sample just accepted
  logic [HW-1:0]   cnthi_q, cnthi_d;
  logic            valid_q, valid_d, first_q, first_d, next_q, next_d;
  logic            last_q, last_d, start_q, start_d, frame_q, frame_d;
  logic            ovf_q, ovf_d, en_prev_q;

  logic            lo_wrap, hi_wrap, frame_end, set_en, excl_en;
  logic            free_any;
  logic [BW-1:0]   free_idx;
  logic [BANKS-1:0] full;

  // During RUN the bank being written must not be picked as "another" bank.
  assign excl_en = (state_q == RUN);

  vis_bank_alloc #(.BANKS(BANKS), .BW(BW)) u_alloc (
    .clock       (clock),
    .reset_n     (reset_n),
    .set_i       (set_en),
    .set_bank_i  (wbank_q),
    .rel_i       (rel_i),
    .rel_bank_i  (rel_bank_i),
    .excl_en_i   (excl_en),
    .excl_bank_i (wbank_q),
    .full_o      (full),
    .free_any_o  (free_any),
    .free_idx_o  (free_idx)
  );

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    blk_d     = blk_q;
    wbank_d   = wbank_q;
    cntlo_d   = cntlo_q;
    cnthi_d   = cnthi_q;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    next_d    = 1'b0;
    last_d    = 1'b0;
    start_d   = 1'b0;
    frame_d   = last_q;                 // frame pulse trails last_o by one cycle
    set_en    = 1'b0;
    lo_wrap   = (lo_q == LO_MAX);
    hi_wrap   = (hi_q == HI_MAX);
    frame_end = 1'b0;
    ovf_d     = ovf_q;
    if (enable_i && !en_prev_q) ovf_d = 1'b0;

    case (state_q)
      IDLE: if (enable_i) state_d = ARM;
      ARM: begin
        if (!enable_i) begin
          state_d = IDLE;               // host gave up while waiting for a bank
        end else if (free_any) begin
          wbank_d = free_idx;
          state_d = RUN;
        end else if (valid_i) begin
          ovf_d = 1'b1;
        end
      end
      RUN: begin
        if (valid_i) begin
          valid_d   = 1'b1;
          cntlo_d   = lo_q;
          cnthi_d   = hi_q;
          first_d   = (lo_q == '0) && (hi_q == '0);
          next_d    = lo_wrap;
          start_d   = first_d && (blk_q == '0);
          frame_end = lo_wrap && hi_wrap && (blk_q == BLK_MAX);
          lo_d      = lo_wrap ? '0 : lo_q + 1'b1;
          if (lo_wrap) hi_d = hi_wrap ? '0 : hi_q + 1'b1;
          if (lo_wrap && hi_wrap) blk_d = (blk_q == BLK_MAX) ? '0 : blk_q + 1'b1;
          if (frame_end) begin
            last_d = 1'b1;
            set_en = 1'b1;
            // enable_i is only honoured here, so a mid-frame drop lets the
            // frame finish before returning to IDLE.
            if (!enable_i)     state_d = IDLE;
            else if (free_any) wbank_d = free_idx;
            else               state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      blk_q     <= '0;
      wbank_q   <= '0;
      cntlo_q   <= '0;
      cnthi_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      next_q    <= 1'b0;
      last_q    <= 1'b0;
      start_q   <= 1'b0;
      frame_q   <= 1'b0;
      ovf_q     <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      blk_q     <= blk_d;
      wbank_q   <= wbank_d;
      cntlo_q   <= cntlo_d;
      cnthi_q   <= cnthi_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      next_q    <= next_d;
      last_q    <= last_d;
      start_q   <= start_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
      en_prev_q <= enable_i;
    end
  end

  assign valid_o     = valid_q;
  assign first_o     = first_q;
  assign next_o      = next_q;
  assign last_o      = last_q;
  assign cntlo_o     = cntlo_q;
  assign cnthi_o     = cnthi_q;
  assign wbank_o     = wbank_q;
  assign vis_start_o = start_q;
  assign vis_frame_o = frame_q;
  assign bank_full_o = full;
  assign overflow_o  = ovf_q;

`ifdef FRAME_SEQ_EN
  logic [15:0]         seq_q, seq_d;
  logic [BANKS*16-1:0] bseq_q, bseq_d;
  logic [BW-1:0]       done_q, done_d;   // bank the last frame completed into

  always_comb begin
    seq_d  = seq_q;
    bseq_d = bseq_q;
    done_d = frame_end ? wbank_q : done_q;
    // Numbered from 0: the slot takes the pre-increment count.
    if (last_q) begin
      seq_d = seq_q + 16'd1;
      bseq_d[int'(done_q)*16 +: 16] = seq_q;
    end
  end

  // NOTE: the per-bank sequence slots are visible outputs that must read 0
  // after reset, so this small register array is reset like any other state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq_q  <= '0;
      bseq_q <= '0;
      done_q <= '0;
    end else begin
      seq_q  <= seq_d;
      bseq_q <= bseq_d;
      done_q <= done_d;
    end
  end

  assign frame_seq_o = seq_q;
  assign bank_seq_o  = bseq_q;
`endif

endmodule

// File: doc/vis_frame_ctrl.md
Name: vis_frame_ctrl

Overview:
- Sequencing controller for the correlator array and its double-banked visibility output SRAM, in the vis_clock domain.
- Consumes the up-rated sample-valid stream from the signal buffer.
- Generates the loop counters and first/next/last strobes the correlator cores need.
- Counts partial-sum blocks into integration frames and owns write-bank allocation, release and overflow handling.

Parameters:
- LOOP0, 3, inner-loop length (samples per correlator sub-block)
- LOOP1, 5, outer-loop length; COUNT = LOOP0*LOOP1 samples per partial-sum block
- BLOCKS, 1024, partial-sum blocks per integration frame
- BANKS, 2, number of output SRAM banks; BSB = $clog2(BANKS)-1

Ports:
- clock, in, 1, vis_clock domain clock
- reset_n, in, 1, synchronous reset, active-low
- enable_i, in, 1, run request from the host control register
- valid_i, in, 1, buffered sample valid (one sample per cycle)
- rel_i, in, 1, reader has finished with a bank
- rel_bank_i, in, BSB+1, bank being released
- valid_o, in-to-out delayed valid_i, 1, sample accepted into the current frame
- first_o, out, 1, first sample of a partial-sum block
- next_o, out, 1, last sample of an inner loop (cntlo wrap)
- last_o, out, 1, final sample of the frame
- cntlo_o, out, $clog2(LOOP0), inner counter
- cnthi_o, out, $clog2(LOOP1), outer counter
- wbank_o, out, BSB+1, bank currently written by the accumulator
- vis_start_o, out, 1, one-cycle pulse with the first sample of a frame
- vis_frame_o, out, 1, one-cycle pulse when a frame completes
- bank_full_o, out, BANKS, per-bank full flags (data awaiting readout)
- overflow_o, out, 1, sticky: samples dropped for lack of a free bank

Behaviour:
- Reset (reset_n low at a clock edge, including mid-frame):
  - State IDLE; all counters, flags, wbank_o and every output = 0.
  - overflow_o cleared.
  - A frame in progress is abandoned without a vis_frame_o pulse.
- Output timing: all outputs registered; strobes and counters lag the accepted valid_i by exactly 1 cycle.
- State machine:
  - IDLE: samples ignored. enable_i=1 -> ARM.
  - ARM: selects the lowest-index bank with bank_full=0, sets wbank_o, -> RUN. No free bank -> stay in ARM; any valid_i seen here sets overflow_o.
  - RUN: each valid_i is accepted.
    - cntlo increments, wrapping at LOOP0-1.
    - On cntlo wrap, cnthi increments, wrapping at LOOP1-1.
    - On cnthi wrap, the block counter increments.
    - first_o=1 when cntlo=cnthi=0; next_o=1 when cntlo=LOOP0-1; valid_o mirrors the accepted valid_i.
    - vis_start_o accompanies first_o of block 0.
  - Frame end (block counter = BLOCKS-1 and both counters at max on an accepted sample):
    - last_o=1; vis_frame_o pulses next cycle; bank_full_o[wbank] set; counters clear.
    - If enable_i=1 and another bank is free in that same cycle: wbank switches and RUN continues with no gap.
    - If enable_i=1 and no bank is free: -> ARM.
    - If enable_i=0: -> IDLE.
- enable_i falling mid-frame: the frame completes normally; controller returns to IDLE at frame end.
- valid_i gaps: counters hold; no strobes.
- Release:
  - rel_i clears bank_full_o[rel_bank_i] at the next edge.
  - Release of a non-full bank, or of an out-of-range index, is ignored.
  - Free-bank checks use registered flags, so a release becomes visible to allocation one cycle later.
  - Release and frame-end full-set in the same cycle on different banks: both take effect.
- overflow_o: cleared only by reset or by an enable_i 0->1 transition.

Optional Feature:
- Macro FRAME_SEQ_EN.
- Defined:
  - Adds output frame_seq_o[15:0] and per-bank register bank_seq_o[BANKS*16-1:0].
  - frame_seq_o increments (wrapping at 65535) on each vis_frame_o.
  - The completed frame's number is latched into that bank's slot.
  - Both are 0 on reset.
- Undefined: ports absent; no sequence logic.

Decomposition:
- Shared package vis_pkg: state enum (IDLE, ARM, RUN); LOOP0/LOOP1/COUNT defaults; BANKS, BSB and the width helpers.
- One natural sub-module: vis_bank_alloc.
  - Owns the full flags, release logic and lowest-free-bank priority encoder.
  - Outputs free_any and free_idx to the FSM.

Test Plan:
- LOOP0=3, LOOP1=5, BLOCKS=4, enable_i=1, valid_i continuous:
  - first_o every 15 accepted samples; next_o on samples 2, 5, 8, ….
  - last_o on sample 59; vis_frame_o one cycle later; bank_full_o=01; wbank_o 0->1 with no gap.
- Continue without releases: second frame fills bank 1, bank_full_o=11, FSM enters ARM; further valid_i sets overflow_o=1.
- From that state, rel_i with bank 0: bank_full_o=10 next cycle; allocation one cycle later; wbank_o=0; vis_start_o with the next accepted sample.
- valid_i toggling 1-0-1: counters hold on 0 cycles; frame still ends after exactly 60 accepted samples.
- enable_i dropped at sample 20: frame completes at sample 59, then IDLE. Reset asserted at sample 30 of a new frame: all outputs 0 next cycle, no vis_frame_o.
- FRAME_SEQ_EN defined, three frames with prompt releases: frame_seq_o=3; bank_seq for bank 0 = 2, bank 1 = 1 (banks alternate 0,1,0; frames numbered from 0).
